wb_unit: RTL
============

# wb_unit

Registered, parametrised write-back unit that replaces the combinational write-back selector. It sits between the MEM stage and the register file, and holds one instruction in a single-entry stage register. Selects the result from `NUM_SRC` sources and aligns and extends sub-word loads. Stalls the upstream pipeline while a load waits for late memory data, and exposes write-back and pending-load information for forwarding and hazard logic.

## Interface
Parameters:
- `WORD_LEN`, default `` `WORD_LEN `` (32): datapath width; legal values 32 or 64.
- `NUM_SRC`, default 4: result sources. 0 = ALU, 1 = memory, 2 = PC+4, 3 = CSR/immediate.
- `REG_ADDR`, default 5: register-file address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: unit accepts this cycle.
- `in_wbsel` in $clog2(NUM_SRC): result source.
- `in_src` in NUM_SRC×WORD_LEN: source data, packed array.
- `in_rd` in REG_ADDR: destination register.
- `in_regwrite` in 1: instruction writes rd.
- `in_size` in 2: load size (`mem_size_t`): B, H, W, D.
- `in_unsigned` in 1: zero-extend the load.
- `in_addr_lo` in $clog2(WORD_LEN/8): low load address bits.
- `mem_rvalid` in 1: memory read data valid.
- `mem_rdata` in WORD_LEN: raw memory word.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out REG_ADDR: write address.
- `rf_wdata` out WORD_LEN: write data; also the forwarding value.
- `pend_valid` out 1: a load is waiting for data.
- `pend_rd` out REG_ADDR: destination of the pending load.

## Operation
- The unit has one entry and three states: EMPTY, WAIT_MEM, READY.
- `in_ready` = !rst && (state == EMPTY || state == READY). READY always drains in one cycle, and the register file never back-pressures.
- An instruction is accepted when `in_valid && in_ready`.
- Accept with `in_wbsel` != 1, or with `in_wbsel` == 1 and `mem_rvalid` high in the same cycle:
  - the selected data is captured, with load data first aligned and extended;
  - next state is READY.
- Accept with `in_wbsel` == 1 and `mem_rvalid` low:
  - rd, size, unsigned and addr_lo are captured;
  - next state is WAIT_MEM.
- WAIT_MEM + `mem_rvalid`: the aligned data is captured and next state is READY.
- WAIT_MEM without `mem_rvalid`: the unit stays in WAIT_MEM and `in_ready` stays 0.
- READY with no accept: next state is EMPTY.
- `rf_we` = (state == READY) && regwrite && (rd != 0). An x0 write is dropped, but the slot still drains.
- Load alignment:
  - B: byte at addr_lo.
  - H: half selected by addr_lo[msb:1]; addr_lo[0] is ignored.
  - W: word selected by addr_lo[msb:2] when WORD_LEN = 64; the whole word when WORD_LEN = 32.
  - D: whole word. D is illegal when WORD_LEN = 32; it is then treated as W.
  - The result is sign-extended unless `in_unsigned` is set.
- `mem_rvalid` in EMPTY or READY, without a load accept, is ignored.
- `in_wbsel` >= NUM_SRC selects 0 (the ALU).

## Timing
- Reset values:
  - state is EMPTY;
  - `rf_we`, `pend_valid` = 0;
  - `rf_waddr`, `rf_wdata`, `pend_rd` = 0;
  - `in_ready` = 0 while `rst` is high.
- Latency, non-load or load with immediate data: accepted at edge N, `rf_we` high during cycle N+1, register file written at edge N+1.
- Throughput: one instruction per cycle, because READY plus a new accept goes to READY or WAIT_MEM.
- Late load: `mem_rvalid` in cycle M gives `rf_we` in cycle M+1.
- `pend_valid` = (state == WAIT_MEM), with `pend_rd` registered at accept. Both are valid from the cycle after accept until the cycle in which data arrives, inclusive.
- `rf_*` outputs are driven from the registered entry with no combinational path from inputs, except that `in_ready` depends on `rst`.
- Reset in WAIT_MEM discards the entry. A `mem_rvalid` arriving after reset is ignored.

## Structure
- `wb_pkg`:
  - `mem_size_t` enum (B, H, W, D);
  - `wb_state_t` enum (EMPTY, WAIT_MEM, READY);
  - source index constants `WB_ALU`, `WB_MEM`, `WB_PC4`, `WB_CSR`.
- `WORD_LEN` stays in `constants.sv`.
- Sub-module `load_align`: combinational. Inputs are raw word, size, unsigned and addr_lo; output is the aligned WORD_LEN value. It is instantiated once, on the memory-data path.

## Test plan
- ALU op, `in_wbsel` = 0, src0 = 0x0000_1234, rd = 5: `rf_we` = 1 with waddr 5 and wdata 0x0000_1234 exactly one cycle after accept.
- Load B signed, addr_lo = 3, `mem_rdata` = 0x80FF_0000, `mem_rvalid` same cycle: wdata = 0xFFFF_FF80. Repeat with `in_unsigned` set: wdata = 0x0000_0080.
- Load H, addr_lo = 2, `mem_rvalid` delayed 3 cycles, `mem_rdata` = 0x7FFE_0000:
  - `pend_valid` = 1 with `pend_rd` correct for 3 cycles;
  - `in_ready` = 0 for those cycles;
  - then wdata = 0x0000_7FFE.
- Back-to-back ALU ops to rd 1, 2, 3 with `in_valid` held: `in_ready` stays 1, and `rf_we` is high on 3 consecutive cycles with addresses 1, 2, 3.
- Write to rd = 0 with src0 = 0xDEAD_BEEF: `rf_we` stays 0, and the next instruction is accepted the following cycle.
- `rst` asserted while in WAIT_MEM, then `mem_rvalid` pulses: all outputs are 0, no write occurs, and `in_ready` = 1 after `rst` drops.

Source files
------------

// File: rtl/wb_pkg.sv
// Write-back stage types: load sizes, FSM states, result-source indices.
// No logic; shared by wb_unit and load_align.
// Source indices match the in_src packing order.
package wb_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    READY    = 2'd2
  } wb_state_t;

  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_PC4 = 2;
  localparam int WB_CSR = 3;

endpackage

// File: rtl/constants.sv
// Global datapath constants shared across the core.
// Single source for the machine word width (32 or 64).
// Included/compiled ahead of any module that uses `WORD_LEN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// File: rtl/wb_unit_load_align.sv
// Load aligner: extracts B/H/W/D from a raw memory word and extends it.
// Purely combinational, zero latency.
// No backpressure; D on a 32-bit datapath degrades to W.
import wb_pkg::*;

module load_align #(
  parameter int WORD_LEN = 32
) (
  input  logic [WORD_LEN-1:0]           raw,
  input  mem_size_t                     size,
  input  logic                          is_unsigned,
  input  logic [$clog2(WORD_LEN/8)-1:0] addr_lo,
  output logic [WORD_LEN-1:0]           aligned
);

  localparam int OW = $clog2(WORD_LEN);
  // Word offset only exists on a 64-bit datapath (bit 5 of the bit offset).
  localparam logic [OW-1:0] WORD_MASK = (WORD_LEN == 64) ? OW'(32) : OW'(0);
  // Clearing bit 3 of the bit offset drops addr_lo[0] for halfwords.
  localparam logic [OW-1:0] HALF_MASK = ~OW'(8);

  logic [OW-1:0] byte_off;
  logic [OW-1:0] half_off;
  logic [OW-1:0] word_off;
  logic [7:0]    b_v;
  logic [15:0]   h_v;
  logic [31:0]   w_v;

  assign byte_off = {addr_lo, 3'b000};
  assign half_off = byte_off & HALF_MASK;
  assign word_off = byte_off & WORD_MASK;

  assign b_v = raw[byte_off +: 8];
  assign h_v = raw[half_off +: 16];
  assign w_v = raw[word_off +: 32];

  // Select the field for the access size, then zero- or sign-extend it.
  always_comb begin
    aligned = '0;
    case (size)
      MEM_B:   aligned = is_unsigned ? WORD_LEN'(b_v) : WORD_LEN'($signed(b_v));
      MEM_H:   aligned = is_unsigned ? WORD_LEN'(h_v) : WORD_LEN'($signed(h_v));
      MEM_W:   aligned = is_unsigned ? WORD_LEN'(w_v) : WORD_LEN'($signed(w_v));
      default: aligned = (WORD_LEN == 64) ? raw
                       : (is_unsigned ? WORD_LEN'(w_v) : WORD_LEN'($signed(w_v)));
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Registered write-back stage: one-entry buffer between MEM and the register file.
// Latency 1 cycle from accept (or from late mem_rvalid) to rf_we.
// Holds in_ready low only while a load waits for memory data.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

import wb_pkg::*;

module wb_unit #(
  parameter int WORD_LEN = `WORD_LEN,
  parameter int NUM_SRC  = 4,
  parameter int REG_ADDR = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [$clog2(NUM_SRC)-1:0]          in_wbsel,
  input  logic [NUM_SRC-1:0][WORD_LEN-1:0]    in_src,
  input  logic [REG_ADDR-1:0]                 in_rd,
  input  logic                                in_regwrite,
  input  mem_size_t                           in_size,
  input  logic                                in_unsigned,
  input  logic [$clog2(WORD_LEN/8)-1:0]       in_addr_lo,
  input  logic                                mem_rvalid,
  input  logic [WORD_LEN-1:0]                 mem_rdata,
  output logic                                rf_we,
  output logic [REG_ADDR-1:0]                 rf_waddr,
  output logic [WORD_LEN-1:0]                 rf_wdata,
  output logic                                pend_valid,
  output logic [REG_ADDR-1:0]                 pend_rd
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(WORD_LEN / 8);

  wb_state_t             state_q, state_d;
  logic [REG_ADDR-1:0]   rd_q, rd_d;
  logic                  regwrite_q, regwrite_d;
  mem_size_t             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [AW-1:0]         addr_lo_q, addr_lo_d;
  logic [WORD_LEN-1:0]   data_q, data_d;

  logic                  accept;
  logic [SEL_W-1:0]      sel;
  logic                  is_load;
  mem_size_t             al_size;
  logic                  al_uns;
  logic [AW-1:0]         al_addr;
  logic [WORD_LEN-1:0]   al_data;

  assign in_ready = !rst && (state_q != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // Out-of-range source selects fall back to the ALU result.
  always_comb begin
    sel = in_wbsel;
    if (int'(in_wbsel) >= NUM_SRC) sel = SEL_W'(WB_ALU);
  end

  assign is_load = (sel == SEL_W'(WB_MEM));

  // While waiting, the aligner works from the captured load attributes.
  always_comb begin
    al_size = in_size;
    al_uns  = in_unsigned;
    al_addr = in_addr_lo;
    if (state_q == WAIT_MEM) begin
      al_size = size_q;
      al_uns  = uns_q;
      al_addr = addr_lo_q;
    end
  end

  load_align #(.WORD_LEN(WORD_LEN)) u_align (
    .raw         (mem_rdata),
    .size        (al_size),
    .is_unsigned (al_uns),
    .addr_lo     (al_addr),
    .aligned     (al_data)
  );

  // Next-state and entry update for the single-entry stage.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_lo_d  = addr_lo_q;
    data_d     = data_q;
    case (state_q)
      WAIT_MEM: begin
        if (mem_rvalid) begin
          data_d  = al_data;
          state_d = READY;
        end
      end
      default: begin
        if (accept) begin
          rd_d       = in_rd;
          regwrite_d = in_regwrite;
          size_d     = in_size;
          uns_d      = in_unsigned;
          addr_lo_d  = in_addr_lo;
          if (is_load && !mem_rvalid) begin
            state_d = WAIT_MEM;
          end else begin
            data_d  = is_load ? al_data : in_src[sel];
            state_d = READY;
          end
        end else begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  // Stage register; reset discards any entry, including a waiting load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      size_q     <= MEM_B;
      uns_q      <= 1'b0;
      addr_lo_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_lo_q  <= addr_lo_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode only registered state; x0 writes are suppressed.
  assign rf_we      = (state_q == READY) && regwrite_q && (rd_q != '0);
  assign rf_waddr   = rd_q;
  assign rf_wdata   = data_q;
  assign pend_valid = (state_q == WAIT_MEM);
  assign pend_rd    = pend_valid ? rd_q : '0;

endmodule
